sparse_nway_joiner: RTL and testbench

Parametrised N-input sparse stream joiner for the sparse dataflow tiles, successor to the two-input intersect/union unit. It merges `NUM_IN` sorted coordinate/position streams into one coordinate stream plus one position stream per input, in either intersection or union mode. Each input has its own buffering FIFO, so input `ready` never depends combinationally on `valid`. The block sits between the level scanners and the downstream ALU/reducer tiles and reuses the standard 17-bit token format (bit 16 = control).

---
 rtl/sparse_nway_joiner.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sparse_nway_joiner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_nway_joiner.sv
// N-input sparse coordinate/position stream joiner (intersect or union) with per-input FIFOs.
// Optional cycle_count/emit_count outputs when SPARSE_JOINER_PERF_EN is defined.
module sparse_nway_joiner #(
  parameter int unsigned NUM_IN     = 3,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic                           flush,
  input  logic                           tile_en,
  input  logic                           joiner_op,
  input  logic [NUM_IN*(DATA_W+1)-1:0]   coord_in,
  input  logic [NUM_IN-1:0]              coord_in_valid,
  output logic [NUM_IN-1:0]              coord_in_ready,
  input  logic [NUM_IN*(DATA_W+1)-1:0]   pos_in,
  input  logic [NUM_IN-1:0]              pos_in_valid,
  output logic [NUM_IN-1:0]              pos_in_ready,
  output logic [DATA_W:0]                coord_out,
  output logic                           coord_out_valid,
  input  logic                           coord_out_ready,
  output logic [NUM_IN*(DATA_W+1)-1:0]   pos_out,
  output logic [NUM_IN-1:0]              pos_out_valid,
  input  logic [NUM_IN-1:0]              pos_out_ready,
  output logic                           error
`ifdef SPARSE_JOINER_PERF_EN
  ,
  output logic [63:0]                    cycle_count,
  output logic [31:0]                    emit_count
`endif
);

  localparam int unsigned TW = DATA_W + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TokDone  = {1'b1, DATA_W'(256)};
  localparam logic [TW-1:0] TokEmpty = {1'b1, DATA_W'(512)};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  state_e state_q, state_d;

  // Per-input FIFO storage
  logic [TW-1:0] c_mem_q [NUM_IN][FIFO_DEPTH];
  logic [TW-1:0] p_mem_q [NUM_IN][FIFO_DEPTH];
  logic [AW-1:0] c_wp_q  [NUM_IN];
  logic [AW-1:0] c_rp_q  [NUM_IN];
  logic [AW-1:0] p_wp_q  [NUM_IN];
  logic [AW-1:0] p_rp_q  [NUM_IN];
  logic [AW:0]   c_cnt_q [NUM_IN];
  logic [AW:0]   p_cnt_q [NUM_IN];

  logic [NUM_IN-1:0] c_push, p_push, pop;
  logic [NUM_IN-1:0] c_full, p_full, present;
  logic [NUM_IN-1:0] is_data, is_stop, is_done;
  logic [TW-1:0]     hc [NUM_IN];
  logic [TW-1:0]     hp [NUM_IN];

  // Output stage
  logic                         cv_q;
  logic [TW-1:0]                co_q;
  logic [NUM_IN-1:0]            pv_q;
  logic [NUM_IN-1:0][TW-1:0]    po_q;
  logic                         err_q;
  logic                         union_q;

  // Join decision
  logic                         want_emit, want_err, to_done;
  logic [NUM_IN-1:0]            want_pop;
  logic [TW-1:0]                em_coord;
  logic [NUM_IN-1:0][TW-1:0]    em_pos;
  logic [DATA_W-1:0]            min_c, max_c;
  logic [7:0]                   min_lvl;
  logic                         stop_same;
  logic [TW-1:0]                tok_stop;

  logic out_en, slot_free, act, emit, err_set, go_done;

  // Handshakes are only live when the tile is enabled, clocked and out of reset
  assign out_en = tile_en & clk_en & ~rst & ~flush;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      c_full[i]  = (c_cnt_q[i] == (AW+1)'(FIFO_DEPTH));
      p_full[i]  = (p_cnt_q[i] == (AW+1)'(FIFO_DEPTH));
      present[i] = (c_cnt_q[i] != '0) && (p_cnt_q[i] != '0);
      hc[i]      = c_mem_q[i][c_rp_q[i]];
      hp[i]      = p_mem_q[i][p_rp_q[i]];
      is_data[i] = ~hc[i][DATA_W];
      is_stop[i] = hc[i][DATA_W] && (hc[i][DATA_W-1:8] == '0);
      is_done[i] = (hc[i] == TokDone);
      coord_in_ready[i] = out_en && (state_q != StDone) && (!c_full[i] || pop[i]);
      pos_in_ready[i]   = out_en && (state_q != StDone) && (!p_full[i] || pop[i]);
      c_push[i]  = coord_in_valid[i] && coord_in_ready[i];
      p_push[i]  = pos_in_valid[i] && pos_in_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (c_push[i]) c_mem_q[i][c_wp_q[i]] <= coord_in[i*TW +: TW];
        if (p_push[i]) p_mem_q[i][p_wp_q[i]] <= pos_in[i*TW +: TW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_IN; i++) begin
        c_wp_q[i]  <= '0;
        c_rp_q[i]  <= '0;
        p_wp_q[i]  <= '0;
        p_rp_q[i]  <= '0;
        c_cnt_q[i] <= '0;
        p_cnt_q[i] <= '0;
      end
    end else if (clk_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (c_push[i]) c_wp_q[i] <= c_wp_q[i] + 1'b1;
        if (p_push[i]) p_wp_q[i] <= p_wp_q[i] + 1'b1;
        if (pop[i]) begin
          c_rp_q[i] <= c_rp_q[i] + 1'b1;
          p_rp_q[i] <= p_rp_q[i] + 1'b1;
        end
        c_cnt_q[i] <= c_cnt_q[i] + (AW+1)'(c_push[i]) - (AW+1)'(pop[i]);
        p_cnt_q[i] <= p_cnt_q[i] + (AW+1)'(p_push[i]) - (AW+1)'(pop[i]);
      end
    end
  end

  // Head analysis and join decision, independent of whether it may act this cycle
  always_comb begin
    min_c     = '1;
    max_c     = '0;
    min_lvl   = '1;
    stop_same = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (is_data[i]) begin
        if (hc[i][DATA_W-1:0] < min_c) min_c = hc[i][DATA_W-1:0];
        if (hc[i][DATA_W-1:0] > max_c) max_c = hc[i][DATA_W-1:0];
      end
      if (is_stop[i] && (hc[i][7:0] < min_lvl)) min_lvl = hc[i][7:0];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (is_stop[i] && (hc[i][7:0] != min_lvl)) stop_same = 1'b0;
    end
    tok_stop  = {1'b1, {(DATA_W-8){1'b0}}, min_lvl};

    want_emit = 1'b0;
    want_pop  = '0;
    want_err  = 1'b0;
    to_done   = 1'b0;
    em_coord  = '0;
    em_pos    = '0;

    if (&is_done) begin
      want_emit = 1'b1;
      want_pop  = '1;
      to_done   = 1'b1;
      em_coord  = TokDone;
      for (int i = 0; i < NUM_IN; i++) em_pos[i] = TokDone;
    end else if (|is_data) begin
      if (union_q) begin
        want_emit = 1'b1;
        em_coord  = {1'b0, min_c};
        for (int i = 0; i < NUM_IN; i++) begin
          if (is_data[i] && (hc[i][DATA_W-1:0] == min_c)) begin
            want_pop[i] = 1'b1;
            em_pos[i]   = hp[i];
          end else begin
            em_pos[i]   = TokEmpty;
          end
        end
      end else if ((&is_data) && (min_c == max_c)) begin
        want_emit = 1'b1;
        want_pop  = '1;
        em_coord  = {1'b0, min_c};
        for (int i = 0; i < NUM_IN; i++) em_pos[i] = hp[i];
      end else if (&is_data) begin
        for (int i = 0; i < NUM_IN; i++) want_pop[i] = (hc[i][DATA_W-1:0] < max_c);
      end else begin
        // Data mixed with stops: drain data until every head reaches its stop
        want_pop = is_data;
      end
    end else if (&is_stop) begin
      want_emit = 1'b1;
      want_pop  = '1;
      want_err  = ~stop_same;
      em_coord  = tok_stop;
      for (int i = 0; i < NUM_IN; i++) em_pos[i] = tok_stop;
    end else begin
      // Malformed mix of stops with done/empty: flag it and drain toward Done
      want_err = 1'b1;
      want_pop = ~is_done;
    end
  end

  always_comb begin
    slot_free = !cv_q || (coord_out_ready && out_en);
    for (int i = 0; i < NUM_IN; i++) begin
      if (pv_q[i] && !(pos_out_ready[i] && out_en)) slot_free = 1'b0;
    end
    act     = (state_q == StRun) && (&present) && out_en;
    emit    = act && want_emit && slot_free;
    pop     = (act && (!want_emit || slot_free)) ? want_pop : '0;
    err_set = act && want_err && (!want_emit || slot_free);
    go_done = emit && to_done;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StRun;
      StRun:   if (go_done) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= StIdle;
      union_q <= 1'b0;
      err_q   <= 1'b0;
      cv_q    <= 1'b0;
      co_q    <= '0;
      pv_q    <= '0;
      po_q    <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (state_q == StIdle) union_q <= joiner_op;
      if (err_set) err_q <= 1'b1;
      if (emit) begin
        cv_q <= 1'b1;
        co_q <= em_coord;
        pv_q <= '1;
        po_q <= em_pos;
      end else begin
        if (coord_out_ready && out_en) cv_q <= 1'b0;
        pv_q <= pv_q & ~(pos_out_ready & {NUM_IN{out_en}});
      end
    end
  end

  assign coord_out       = co_q;
  assign coord_out_valid = cv_q & out_en;
  assign pos_out         = po_q;
  assign pos_out_valid   = pv_q & {NUM_IN{out_en}};
  assign error           = err_q;

`ifdef SPARSE_JOINER_PERF_EN
  logic        started_q, stopped_q;
  logic [63:0] cyc_q;
  logic [31:0] emc_q;
  logic        any_in_v;

  assign any_in_v = (|coord_in_valid) | (|pos_in_valid);

  // Counts every edge from the first input valid through the Done emission, inclusive
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      started_q <= 1'b0;
      stopped_q <= 1'b0;
      cyc_q     <= '0;
      emc_q     <= '0;
    end else if (clk_en) begin
      if (!stopped_q && (started_q || any_in_v)) begin
        started_q <= 1'b1;
        cyc_q     <= cyc_q + 64'd1;
      end
      if (go_done) stopped_q <= 1'b1;
      if (emit) emc_q <= emc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
  assign emit_count  = emc_q;
`endif

endmodule

// File: tb/tb_sparse_nway_joiner.sv
// Directed scoreboard bench for sparse_nway_joiner: a 2-input and a 3-input instance.
module tb_sparse_nway_joiner;

  localparam logic [16:0] TS0 = 17'h10000;
  localparam logic [16:0] TS1 = 17'h10001;
  localparam logic [16:0] TD  = 17'h10100;
  localparam logic [16:0] TE  = 17'h10200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clk_en, flush, tile_en, joiner_op;

  logic [33:0] c2_in, p2_in, p2_out;
  logic [1:0]  c2_v, c2_r, p2_v, p2_r, p2_ov, p2_or;
  logic [16:0] c2_out;
  logic        c2_ov, c2_or, e2;

  logic [50:0] c3_in, p3_in, p3_out;
  logic [2:0]  c3_v, c3_r, p3_v, p3_r, p3_ov, p3_or;
  logic [16:0] c3_out;
  logic        c3_ov, c3_or, e3;

`ifdef SPARSE_JOINER_PERF_EN
  logic [63:0] cc2, cc3;
  logic [31:0] ec2, ec3;
`endif

  sparse_nway_joiner #(.NUM_IN(2), .DATA_W(16), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .joiner_op(joiner_op),
    .coord_in(c2_in), .coord_in_valid(c2_v), .coord_in_ready(c2_r),
    .pos_in(p2_in), .pos_in_valid(p2_v), .pos_in_ready(p2_r),
    .coord_out(c2_out), .coord_out_valid(c2_ov), .coord_out_ready(c2_or),
    .pos_out(p2_out), .pos_out_valid(p2_ov), .pos_out_ready(p2_or),
    .error(e2)
`ifdef SPARSE_JOINER_PERF_EN
    , .cycle_count(cc2), .emit_count(ec2)
`endif
  );

  sparse_nway_joiner #(.NUM_IN(3), .DATA_W(16), .FIFO_DEPTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .joiner_op(joiner_op),
    .coord_in(c3_in), .coord_in_valid(c3_v), .coord_in_ready(c3_r),
    .pos_in(p3_in), .pos_in_valid(p3_v), .pos_in_ready(p3_r),
    .coord_out(c3_out), .coord_out_valid(c3_ov), .coord_out_ready(c3_or),
    .pos_out(p3_out), .pos_out_valid(p3_ov), .pos_out_ready(p3_or),
    .error(e3)
`ifdef SPARSE_JOINER_PERF_EN
    , .cycle_count(cc3), .emit_count(ec3)
`endif
  );

  int total = 0;
  int bad = 0;
  int step_no = 0;
  int fv_step = -1;
  int done_step = -1;

  logic [16:0] qc [3][$];
  logic [16:0] qp [3][$];
  logic [16:0] exp_c [$];
  logic [16:0] exp_p [3][$];
  logic        cor_g;
  logic [2:0]  por_g;
  bit          bp_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return exp_c.size() + exp_p[0].size() + exp_p[1].size() + exp_p[2].size();
  endfunction

  task automatic push_in(input int i, input logic [16:0] c, input logic [16:0] p);
    qc[i].push_back(c);
    qp[i].push_back(p);
  endtask

  task automatic expect_out(input int n, input logic [16:0] c, input logic [16:0] p0,
                            input logic [16:0] p1, input logic [16:0] p2);
    exp_c.push_back(c);
    exp_p[0].push_back(p0);
    exp_p[1].push_back(p1);
    if (n == 3) exp_p[2].push_back(p2);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 3; i++) begin
      qc[i].delete();
      qp[i].delete();
    end
  endtask

  // One cycle: drive at negedge, sample handshakes 1 time unit later, before the posedge
  task automatic step(input int sel);
    logic [2:0]  cv, pv, gcr, gpr, gpv, por;
    logic [16:0] cd [3];
    logic [16:0] pd [3];
    logic [16:0] gpo [3];
    logic [16:0] gco, e;
    logic        gov;
    @(negedge clk);
    step_no++;
    for (int i = 0; i < 3; i++) begin
      cv[i] = (i < sel) && (qc[i].size() > 0);
      pv[i] = (i < sel) && (qp[i].size() > 0);
      cd[i] = cv[i] ? qc[i][0] : 17'h0;
      pd[i] = pv[i] ? qp[i][0] : 17'h0;
    end
    por = por_g;
    if (bp_en) por[1] = 1'($urandom_range(0, 1));
    if (sel == 2) begin
      c2_in = {cd[1], cd[0]};  p2_in = {pd[1], pd[0]};
      c2_v = cv[1:0];  p2_v = pv[1:0];  c2_or = cor_g;  p2_or = por[1:0];
      c3_v = '0;  p3_v = '0;  c3_or = 1'b1;  p3_or = '1;
    end else begin
      c3_in = {cd[2], cd[1], cd[0]};  p3_in = {pd[2], pd[1], pd[0]};
      c3_v = cv;  p3_v = pv;  c3_or = cor_g;  p3_or = por;
      c2_v = '0;  p2_v = '0;  c2_or = 1'b1;  p2_or = '1;
    end
    if ((cv != '0) && (fv_step < 0)) fv_step = step_no;
    #1;
    if (sel == 2) begin
      gcr = {1'b0, c2_r};  gpr = {1'b0, p2_r};  gpv = {1'b0, p2_ov};
      gov = c2_ov;  gco = c2_out;
      gpo[0] = p2_out[16:0];  gpo[1] = p2_out[33:17];  gpo[2] = 17'h0;
    end else begin
      gcr = c3_r;  gpr = p3_r;  gpv = p3_ov;  gov = c3_ov;  gco = c3_out;
      for (int i = 0; i < 3; i++) gpo[i] = p3_out[i*17 +: 17];
    end
    for (int i = 0; i < sel; i++) begin
      if (cv[i] && gcr[i]) void'(qc[i].pop_front());
      if (pv[i] && gpr[i]) void'(qp[i].pop_front());
    end
    if (gov && (gco === TD) && (done_step < 0)) done_step = step_no;
    if (gov && cor_g) begin
      if (exp_c.size() == 0) check("coord_extra", gco, 17'h1ffff);
      else begin
        e = exp_c.pop_front();
        check("coord", gco, e);
      end
    end
    for (int i = 0; i < sel; i++) begin
      if (gpv[i] && por[i]) begin
        if (exp_p[i].size() == 0) check($sformatf("pos%0d_extra", i), gpo[i], 17'h1ffff);
        else begin
          e = exp_p[i].pop_front();
          check($sformatf("pos%0d", i), gpo[i], e);
        end
      end
    end
  endtask

  task automatic do_reset(input int sel);
    clear_stim();
    rst = 1'b1;
    step(sel);
    step(sel);
    rst = 1'b0;
    fv_step = -1;
    done_step = -1;
  endtask

  task automatic run(input int sel, input int budget);
    int k = 0;
    while ((pending() != 0) && (k < budget)) begin
      step(sel);
      k++;
    end
    check("drain", pending(), 0);
    repeat (4) step(sel);
  endtask

  task automatic load_union(input bit with_exp);
    push_in(0, 17'd1, 17'd0);  push_in(0, 17'd3, 17'd1);
    push_in(0, TS0, TS0);      push_in(0, TD, TD);
    push_in(1, 17'd2, 17'd0);  push_in(1, 17'd3, 17'd1);
    push_in(1, TS0, TS0);      push_in(1, TD, TD);
    if (with_exp) begin
      expect_out(2, 17'd1, 17'd0, TE, 17'h0);
      expect_out(2, 17'd2, TE, 17'd0, 17'h0);
      expect_out(2, 17'd3, 17'd1, 17'd1, 17'h0);
      expect_out(2, TS0, TS0, TS0, 17'h0);
      expect_out(2, TD, TD, TD, 17'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;  clk_en = 1'b1;  flush = 1'b0;  tile_en = 1'b1;  joiner_op = 1'b1;
    cor_g = 1'b1;  por_g = '1;  bp_en = 1'b0;
    c2_in = '0;  p2_in = '0;  c2_v = '0;  p2_v = '0;  c2_or = 1'b1;  p2_or = '1;
    c3_in = '0;  p3_in = '0;  c3_v = '0;  p3_v = '0;  c3_or = 1'b1;  p3_or = '1;

    // Reset state
    do_reset(2);
    step(2);
    check("rst_coord_valid", c2_ov, 1'b0);
    check("rst_pos_valid", p2_ov, 2'b00);
    check("rst_error", e2, 1'b0);
    check("rst_coord_out", c2_out, 17'h0);
    check("rst_ready_empty", c2_r, 2'b11);
    tile_en = 1'b0;
    #1;
    check("tile_en_ready", c2_r, 2'b00);
    tile_en = 1'b1;

    // Union, two inputs
    do_reset(2);
    load_union(1'b1);
    run(2, 100);
    check("union_error", e2, 1'b0);
`ifdef SPARSE_JOINER_PERF_EN
    check("emit_count", ec2, 32'd5);
    check("cycle_count", cc2, 64'(done_step - fv_step));
`endif

    // Intersect, three inputs
    joiner_op = 1'b0;
    do_reset(3);
    push_in(0, 17'd1, 17'd0);  push_in(0, 17'd4, 17'd1);  push_in(0, 17'd5, 17'd2);
    push_in(0, TS0, TS0);      push_in(0, TD, TD);
    push_in(1, 17'd4, 17'd0);  push_in(1, 17'd5, 17'd1);
    push_in(1, TS0, TS0);      push_in(1, TD, TD);
    push_in(2, 17'd2, 17'd0);  push_in(2, 17'd4, 17'd1);
    push_in(2, TS0, TS0);      push_in(2, TD, TD);
    expect_out(3, 17'd4, 17'd1, 17'd0, 17'd1);
    expect_out(3, TS0, TS0, TS0, TS0);
    expect_out(3, TD, TD, TD, TD);
    run(3, 100);
    check("isect_error", e3, 1'b0);

    // Union with random backpressure on pos_out[1]
    joiner_op = 1'b1;
    do_reset(2);
    bp_en = 1'b1;
    load_union(1'b1);
    run(2, 300);
    bp_en = 1'b0;

    // Stop-level mismatch
    do_reset(2);
    push_in(0, TS0, TS0);  push_in(0, TD, TD);
    push_in(1, TS1, TS1);  push_in(1, TD, TD);
    expect_out(2, TS0, TS0, TS0, 17'h0);
    expect_out(2, TD, TD, TD, 17'h0);
    run(2, 100);
    check("mismatch_error", e2, 1'b1);
    repeat (5) step(2);
    check("mismatch_error_held", e2, 1'b1);
    do_reset(2);
    check("error_cleared", e2, 1'b0);

    // Reset mid-stream with full FIFOs, then replay
    do_reset(2);
    cor_g = 1'b0;
    por_g = '0;
    load_union(1'b0);
    repeat (6) step(2);
    check("full_coord_ready", c2_r, 2'b00);
    check("full_pos_ready", p2_r, 2'b00);
    check("full_held_valid", c2_ov, 1'b1);
    clear_stim();
    rst = 1'b1;
    step(2);
    check("midrst_ready", c2_r, 2'b00);
    check("midrst_valid", c2_ov, 1'b0);
    rst = 1'b0;
    cor_g = 1'b1;
    por_g = '1;
    step(2);
    check("post_rst_coord_valid", c2_ov, 1'b0);
    check("post_rst_pos_valid", p2_ov, 2'b00);
    check("post_rst_empty", c2_r, 2'b11);
    load_union(1'b1);
    run(2, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
